// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: bus width, stop encodings,
// multiply/divide sequencer states and counter preload helper.
package pipe_ctrl_pkg;

    localparam int PIPE_STALL_W = 6;
    localparam int CNT_W        = 6;

    localparam logic [PIPE_STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [PIPE_STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [PIPE_STALL_W-1:0] STALL_EX   = 6'b001111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // The IDLE cycle that accepts the op and the RUN cycle at cnt==0 both stall,
    // so the preload is two short of the total latency.
    function automatic logic [CNT_W-1:0] mdu_load(input logic is_div, input int mul_lat,
                                                  input int div_lat);
        return is_div ? CNT_W'(div_lat - 2) : CNT_W'(mul_lat - 2);
    endfunction

endpackage

// File: rtl/pipe_ctrl_mdu_seq.sv
// Multiply/divide sequencer: holds EX for a fixed latency, then pulses done.
//   state   | meaning
//   IDLE    | no op in flight; a start holds EX this cycle and loads cnt
//   RUN     | op executing; cnt counts down to 0
//   DONE    | result valid for one cycle; EX advances
module mdu_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done,
    output logic hold
);

    mdu_state_e       state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_RUN;
                        cnt   <= mdu_load(is_div, MUL_LAT, DIV_LAT);
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign hold = ((state == ST_IDLE) && start) || busy;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: merges hazard and MDU requests into the per-stage
// stop vector and keeps a saturating count of stalled cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W = PIPE_STALL_W,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stallreq_id,
    input  logic               stallreq_ex,
    input  logic               mdu_start,
    input  logic               mdu_is_div,
    output logic [STALL_W-1:0] stall,
    output logic               mdu_busy,
    output logic               mdu_done,
    output logic [31:0]        stall_cycles
);

    logic mdu_hold;

    mdu_seq #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT)
    ) u_mdu_seq (
        .clk   (clk),
        .resetn(resetn),
        .start (mdu_start),
        .is_div(mdu_is_div),
        .busy  (mdu_busy),
        .done  (mdu_done),
        .hold  (mdu_hold)
    );

    // Stop vector is forced quiet while reset is asserted, whatever the requests say.
    always_comb begin
        stall = STALL_W'(STALL_NONE);
        if (resetn) begin
            if (mdu_hold || stallreq_ex) begin
                stall = STALL_W'(STALL_EX);
            end else if (stallreq_id) begin
                stall = STALL_W'(STALL_ID);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if ((stall != '0) && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STALL_W, default 6, meaning width of the stall bus (bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB).
REQ-002 SHALL have parameter MUL_LAT, default 4, meaning total EX stall cycles for a multiply (legal 2..63).
REQ-003 SHALL have parameter DIV_LAT, default 33, meaning total EX stall cycles for a divide (legal 2..63).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  meaning the reset, asynchronous and active-low.
REQ-006 SHALL have port stallreq_id  input  1  meaning ID load-use hazard request.
REQ-007 SHALL have port stallreq_ex  input  1  meaning EX generic busy request.
REQ-008 SHALL have port mdu_start  input  1  meaning the EX instruction is a mult/div (level, held while in EX).
REQ-009 SHALL have port mdu_is_div  input  1  meaning 1 = divide, 0 = multiply; sampled with mdu_start.
REQ-010 SHALL have port stall  output  STALL_W  meaning the per-stage stop vector to all pipeline stages.
REQ-011 SHALL have port mdu_busy  output  1  meaning the sequencer is in RUN.
REQ-012 SHALL have port mdu_done  output  1  meaning one-cycle pulse; MDU result valid, EX advances this cycle.
REQ-013 SHALL have port stall_cycles  output  32  meaning saturating count of cycles with stall != 0.

Function
REQ-014 SHALL encode stall as: stage i holds when stall[i]=1; a bubble enters stage i+1 when stall[i]=1 and stall[i+1]=0.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; 6-bit down-counter cnt.
REQ-016 IDLE: mdu_start=1 -> RUN with cnt = (mdu_is_div ? DIV_LAT : MUL_LAT) - 2; otherwise stay IDLE.
REQ-017 RUN: cnt != 0 -> decrement; cnt == 0 -> DONE.
REQ-018 DONE: unconditionally -> IDLE; mdu_start ignored (same instruction still in EX).
REQ-019 SHALL ignore mdu_start and mdu_is_div while in RUN.
REQ-020 stall (combinational): 6'b001111 when (IDLE and mdu_start) or RUN or stallreq_ex; else 6'b000111 when stallreq_id; else 0.
REQ-021 In DONE, stall SHALL be driven only by stallreq_ex/stallreq_id per REQ-020 (MDU contribution released).
REQ-022 Total MDU-driven stall cycles SHALL equal MUL_LAT or DIV_LAT exactly; mdu_done=1 only in DONE.
REQ-023 mdu_busy = (state == RUN).
REQ-024 Simultaneous stallreq_ex and stallreq_id: EX pattern 6'b001111 wins.
REQ-025 Back-to-back MDU ops: second op's mdu_start seen in IDLE the cycle after DONE; no lost or merged op.
REQ-026 stall_cycles SHALL increment by 1 each cycle stall != 0 and hold at 32'hFFFF_FFFF.

Reset
REQ-027 resetn=0 SHALL asynchronously force state=IDLE, cnt=0, stall_cycles=0, mdu_done=0, mdu_busy=0.
REQ-028 During reset, stall SHALL be 0 regardless of inputs; reset mid-RUN aborts the op with no mdu_done pulse.
REQ-029 After resetn rises, first edge SHALL apply normal IDLE behaviour.

Structure
REQ-030 STALL_W, the stop/no-stop encodings and the state encodings SHALL reside in the shared defines header.
REQ-031 The block SHALL be self-contained in one module.
REQ-032 A sub-module mdu_seq (FSM plus counter, outputs busy/done/hold) is permitted; the stall mux and the counter stay in pipe_ctrl.

Verification
REQ-033 Drive stallreq_id=1 for 1 cycle -> stall=6'b000111 that cycle, then 0; stall_cycles increments by 1.
REQ-034 mdu_start=1 with mdu_is_div=0, held until mdu_done -> stall=6'b001111 for exactly 4 cycles, mdu_busy for 3, mdu_done on the 5th cycle with stall=0.
REQ-035 Divide (mdu_is_div=1) followed immediately by a multiply -> 33 stall cycles, one mdu_done, 1 free cycle, then 4 stall cycles, one mdu_done.
REQ-036 stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111.
REQ-037 resetn low at cnt=10 of a divide -> stall=0, state IDLE, no mdu_done; a fresh divide after release still takes 33 cycles.
REQ-038 Preload stall_cycles to 32'hFFFF_FFFE (force), stall for 3 cycles -> value holds at 32'hFFFF_FFFF.
